// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// lock_pkg : shared types and constants for the keypad door lock sequencer.
// Revision : 1.0
// ============================================================================
package lock_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENTRY    = 2'd1,
      UNLOCKED = 2'd2,
      LOCKOUT  = 2'd3
   } state_t;

   localparam int DIGIT_W   = 4;
   localparam int KEY_N     = 10;

   localparam int DEF_CODE0 = 5;
   localparam int DEF_CODE1 = 2;
   localparam int DEF_CODE2 = 4;
   localparam int DEF_CODE3 = 1;
   localparam int DEF_CODE4 = 9;

endpackage
`default_nettype wire

// File: rtl/lock_key_event.sv
`default_nettype none
// ============================================================================
// lock_key_event : turns raw key levels into single press events with digit.
// Revision : 1.0
// ============================================================================
module lock_key_event
   import lock_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic [KEY_N-1:0]   Key,
   output logic               evt,
   output logic               evt_valid,
   output logic [DIGIT_W-1:0] evt_digit
);

   logic [KEY_N-1:0] key_q;
   logic             one_hot;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) key_q <= '0;
      else       key_q <= Key;
   end

   // Only a transition out of all-released counts; key changes without a release do not.
   assign evt       = (key_q == '0) && (Key != '0);
   assign one_hot   = ((Key & (Key - KEY_N'(1))) == '0);
   assign evt_valid = evt && one_hot;

   always_comb begin
      evt_digit = '0;
      for (int i = 0; i < KEY_N; i++) begin
         if (Key[i]) evt_digit = DIGIT_W'(i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
// lock_sequencer : five-digit code checker with fail counting, lockout and timed unlock.
// Revision : 1.0
// ============================================================================
module lock_sequencer
   import lock_pkg::*;
#(
   parameter int CODE0          = DEF_CODE0,
   parameter int CODE1          = DEF_CODE1,
   parameter int CODE2          = DEF_CODE2,
   parameter int CODE3          = DEF_CODE3,
   parameter int CODE4          = DEF_CODE4,
   parameter int MAX_FAIL       = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int UNLOCK_CYCLES  = 500
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic [KEY_N-1:0] Key,
   input  logic             Dr,
   output logic             Unlock,
   output logic             Lockout,
   output logic [2:0]       Digit_idx,
   output logic [3:0]       Fail_cnt
);

   localparam int MAX_CYC = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
   localparam int TMR_W   = $clog2(MAX_CYC);
   localparam logic [TMR_W-1:0] UNL_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
   localparam logic [TMR_W-1:0] LCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [4:0]       FAIL_LIM = 5'(MAX_FAIL);

   state_t             state, state_n;
   logic [2:0]         idx_n;
   logic [3:0]         fail_n, fail_inc;
   logic [TMR_W-1:0]   timer, timer_n;
   logic               evt, evt_valid;
   logic [DIGIT_W-1:0] evt_digit;

   lock_key_event u_key_event (
      .Clk       (Clk),
      .Reset     (Reset),
      .Key       (Key),
      .evt       (evt),
      .evt_valid (evt_valid),
      .evt_digit (evt_digit)
   );

   function automatic logic [DIGIT_W-1:0] code_at(input logic [2:0] idx);
      case (idx)
         3'd0:    code_at = DIGIT_W'(CODE0);
         3'd1:    code_at = DIGIT_W'(CODE1);
         3'd2:    code_at = DIGIT_W'(CODE2);
         3'd3:    code_at = DIGIT_W'(CODE3);
         default: code_at = DIGIT_W'(CODE4);
      endcase
   endfunction

   assign fail_inc = (Fail_cnt == 4'd15) ? 4'd15 : Fail_cnt + 4'd1;

   always_comb begin
      state_n = state;
      idx_n   = Digit_idx;
      fail_n  = Fail_cnt;
      timer_n = timer;
      case (state)
         IDLE, ENTRY: begin
            // Door switch outranks any press arriving in the same cycle.
            if (Dr) begin
               state_n = IDLE;
               idx_n   = 3'd0;
            end else if (evt) begin
               if (evt_valid && (evt_digit == code_at(Digit_idx))) begin
                  if (Digit_idx == 3'd4) begin
                     state_n = UNLOCKED;
                     idx_n   = 3'd0;
                     fail_n  = 4'd0;
                     timer_n = UNL_LOAD;
                  end else begin
                     state_n = ENTRY;
                     idx_n   = Digit_idx + 3'd1;
                  end
               end else begin
                  idx_n  = 3'd0;
                  fail_n = fail_inc;
                  if (({1'b0, Fail_cnt} + 5'd1) == FAIL_LIM) begin
                     state_n = LOCKOUT;
                     timer_n = LCK_LOAD;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
         end
         UNLOCKED: begin
            if ((timer == '0) || Dr) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer - TMR_W'(1);
            end
         end
         LOCKOUT: begin
            if (timer == '0) begin
               state_n = IDLE;
               fail_n  = 4'd0;
            end else begin
               timer_n = timer - TMR_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         Digit_idx <= 3'd0;
         Fail_cnt  <= 4'd0;
         timer     <= '0;
         Unlock    <= 1'b0;
         Lockout   <= 1'b0;
      end else begin
         state     <= state_n;
         Digit_idx <= idx_n;
         Fail_cnt  <= fail_n;
         timer     <= timer_n;
         Unlock    <= (state_n == UNLOCKED);
         Lockout   <= (state_n == LOCKOUT);
      end
   end

endmodule
`default_nettype wire

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Synchronous controller for the five-digit keypad door lock.
- Turns raw key levels k0..k9 into single press events and checks them in order against the stored code.
- Counts failed attempts and enforces a timed lockout.
- Drives a timed Unlock output; the door switch Dr returns the lock to idle.
- Sits between the keypad/door switch and the strike driver.

Parameters:
- CODE0, 5, first code digit (0-9)
- CODE1, 2, second code digit
- CODE2, 4, third code digit
- CODE3, 1, fourth code digit
- CODE4, 9, fifth code digit
- MAX_FAIL, 3, failed attempts that trigger lockout (1-15)
- LOCKOUT_CYCLES, 1000, lockout duration in clocks (>=2)
- UNLOCK_CYCLES, 500, unlock hold duration in clocks (>=2)

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- Key  input  10  key levels, bit i = key i; already synchronised upstream
- Dr  input  1  door-open switch, level, 1 = open
- Unlock  output  1  strike drive, registered
- Lockout  output  1  high while in LOCKOUT, registered
- Digit_idx  output  3  digits correctly entered so far, 0-4, registered
- Fail_cnt  output  4  failed attempts since last unlock or lockout expiry, registered

Behaviour:
- Reset (async, any time, including mid-entry, mid-unlock or mid-lockout):
  - state=IDLE; Unlock=0, Lockout=0, Digit_idx=0, Fail_cnt=0, timer=0, Key_q=0.
- Press detection:
  - Key_q is Key registered every cycle.
  - A press event occurs in a cycle where Key_q==0 and Key!=0. It is acted on at that clock edge.
  - Event is valid if Key is one-hot; digit = index of the set bit.
  - Event is invalid if more than one bit is set. An invalid event counts as a wrong digit.
  - Held keys and key releases generate no event. Changing keys without passing through 0 generates no event.
- States: IDLE, ENTRY, UNLOCKED, LOCKOUT.
- IDLE / ENTRY (Digit_idx = k):
  - Valid event with digit == CODEk, k<4: Digit_idx=k+1; state=ENTRY.
  - Valid event with digit == CODE4 at k=4: state=UNLOCKED; Unlock=1 from the next cycle; Fail_cnt=0; Digit_idx=0; timer=UNLOCK_CYCLES-1.
  - Wrong or invalid event: Digit_idx=0; state=IDLE; Fail_cnt+1. The wrong key is not re-used as a first digit.
  - If Fail_cnt+1 == MAX_FAIL: state=LOCKOUT; Lockout=1; timer=LOCKOUT_CYCLES-1.
  - Dr==1: state=IDLE, Digit_idx=0, Fail_cnt unchanged; any press event in that cycle is ignored. Dr has priority over key events.
- UNLOCKED:
  - Key events are ignored.
  - Timer decrements every cycle.
  - Timer==0 or Dr==1: state=IDLE, Unlock=0 next cycle.
  - Unlock is therefore high for exactly UNLOCK_CYCLES cycles if Dr stays 0.
- LOCKOUT:
  - Key events and Dr are ignored.
  - Timer decrements every cycle.
  - Timer==0: state=IDLE, Lockout=0, Fail_cnt=0.
  - Lockout is high for exactly LOCKOUT_CYCLES cycles.
- Timer: single shared down-counter, width clog2(max(LOCKOUT_CYCLES, UNLOCK_CYCLES)). It never wraps; it holds at 0 outside UNLOCKED/LOCKOUT.
- Fail_cnt saturates at 15. It is never compared beyond MAX_FAIL.
- Unlock and Lockout are never high together.

Decomposition:
- Package lock_pkg:
  - state enum: IDLE, ENTRY, UNLOCKED, LOCKOUT
  - DIGIT_W=4, KEY_N=10
  - default code digit constants
- Sub-module lock_key_event:
  - Owns Key_q and the edge detect.
  - Outputs evt, evt_valid, evt_digit[3:0]. Combinational on Key/Key_q.
- Top holds the FSM, digit compare mux, timer and fail counter.

Test Plan:
- Correct code 5,2,4,1,9, one-cycle presses separated by idle cycles -> Digit_idx steps 1,2,3,4; Unlock=1 for exactly 500 cycles; Fail_cnt=0.
- 5,2,7 then 5,2,4,1,9 -> after 7: Digit_idx=0, Fail_cnt=1; second attempt unlocks and clears Fail_cnt to 0.
- Three wrong first digits (3,3,3) -> Lockout=1 after third press for 1000 cycles. A full correct code entered during lockout gives no Unlock. After expiry Fail_cnt=0 and the correct code unlocks.
- Key=0x024 (keys 2 and 5 together) at idx 0 -> counted as wrong, Fail_cnt=1. A key held 50 cycles counts once.
- Unlock, then Dr=1 at cycle 100 of unlock -> Unlock=0 next cycle. Dr=1 mid-entry at idx 3 -> Digit_idx=0, Fail_cnt unchanged.
- Reset pulse asserted between clock edges during entry, during UNLOCKED and during LOCKOUT -> all outputs 0 immediately, before the next edge.
